// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: host-transmit state encoding, 40 MHz timing defaults and parity helper.
package ps2_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StInhibit,
    StReq,
    StStart,
    StShift,
    StAck,
    StWaitIdle
  } ps2_tx_state_t;

  localparam int unsigned PS2_INHIBIT_CYCLES_40M = 4000;
  localparam int unsigned PS2_TIMEOUT_CYCLES_40M = 600000;
  localparam int unsigned PS2_FILTER_CYCLES      = 8;

  function automatic logic ps2_odd_parity(input logic [7:0] b);
    return ~^b;
  endfunction

endpackage

// File: rtl/ps2_host_tx_if.sv
// Core-side byte handshake and completion status for the PS/2 host transmitter.
interface ps2_host_tx_if;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic       busy;
  logic       done;
  logic       error;

  modport master (
    output tx_data, tx_valid,
    input  tx_ready, busy, done, error
  );

  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, busy, done, error
  );
endinterface

// File: rtl/ps2_line_sync.sv
// One PS/2 line: 2-flop synchronizer, optional stable-level filter (FilterCycles > 0),
// and a registered falling-edge pulse.
module ps2_line_sync #(
  parameter int unsigned FilterCycles = 0
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic pad_i,
  output logic level_o,
  output logic fall_o
);

  logic s1_q, s2_q, prev_q, fall_q;
  logic level;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s1_q <= 1'b1;
      s2_q <= 1'b1;
    end else begin
      s1_q <= pad_i;
      s2_q <= s1_q;
    end
  end

  if (FilterCycles > 0) begin : g_filter
    localparam int unsigned CntW = $clog2(FilterCycles + 1);
    logic [CntW-1:0] cnt_q;
    logic            filt_q;

    // The filtered level only follows after FilterCycles consecutive differing samples.
    always_ff @(posedge clk_i) begin
      if (rst_i) begin
        filt_q <= 1'b1;
        cnt_q  <= '0;
      end else if (s2_q == filt_q) begin
        cnt_q <= '0;
      end else if (cnt_q == CntW'(FilterCycles - 1)) begin
        filt_q <= s2_q;
        cnt_q  <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end
    end

    assign level = filt_q;
  end else begin : g_direct
    assign level = s2_q;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      prev_q <= 1'b1;
      fall_q <= 1'b0;
    end else begin
      prev_q <= level;
      fall_q <= prev_q & ~level;
    end
  end

  assign level_o = level;
  assign fall_o  = fall_q;

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: request-to-send, 11-bit frame on device clock, ack check.
// Define PS2_TX_FILTER_EN to glitch-filter the device clock before edge detection.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned InhibitCycles = PS2_INHIBIT_CYCLES_40M,
  parameter int unsigned TimeoutCycles = PS2_TIMEOUT_CYCLES_40M,
  parameter int unsigned FilterCycles  = PS2_FILTER_CYCLES
) (
  input  logic         clk_i,
  input  logic         rst_i,
  ps2_host_tx_if.slave tx_if,
  input  logic         ps2_clk_i,
  input  logic         ps2_data_i,
  output logic         ps2_clk_oe_o,
  output logic         ps2_data_oe_o
);

`ifdef PS2_TX_FILTER_EN
  localparam bit FilterOn = 1'b1;
`else
  localparam bit FilterOn = 1'b0;
`endif
  localparam int unsigned ClkFilterCycles = FilterOn ? FilterCycles : 0;
  localparam logic [12:0] InhibLast = 13'(InhibitCycles - 1);
  localparam logic [19:0] WdLast    = 20'(TimeoutCycles - 1);

  logic clk_level, clk_fall, data_level, data_fall;

  ps2_line_sync #(.FilterCycles(ClkFilterCycles)) u_clk_sync (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .pad_i   (ps2_clk_i),
    .level_o (clk_level),
    .fall_o  (clk_fall)
  );

  ps2_line_sync #(.FilterCycles(0)) u_data_sync (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .pad_i   (ps2_data_i),
    .level_o (data_level),
    .fall_o  (data_fall)
  );

  ps2_tx_state_t state_q;
  logic [9:0]    frame_q;
  logic [3:0]    bit_idx_q;
  logic [12:0]   inhib_cnt_q;
  logic [19:0]   wd_q;
  logic          ack_err_q, clk_oe_q, data_oe_q, ready_q, busy_q, done_q, error_q;
  logic          wd_active, wd_expired;

  assign wd_active  = state_q inside {StStart, StShift, StAck, StWaitIdle};
  // A device edge in the expiry cycle wins over the timeout.
  assign wd_expired = (wd_q == WdLast) && !clk_fall;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StIdle;
      frame_q     <= '0;
      bit_idx_q   <= '0;
      inhib_cnt_q <= '0;
      wd_q        <= '0;
      ack_err_q   <= 1'b0;
      clk_oe_q    <= 1'b0;
      data_oe_q   <= 1'b0;
      ready_q     <= 1'b1;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      if (wd_active) wd_q <= clk_fall ? '0 : wd_q + 1'b1;
      if (wd_active && wd_expired) begin
        clk_oe_q  <= 1'b0;
        data_oe_q <= 1'b0;
        busy_q    <= 1'b0;
        done_q    <= 1'b1;
        error_q   <= 1'b1;
        state_q   <= StIdle;
      end else begin
        unique case (state_q)
          StIdle: begin
            clk_oe_q  <= 1'b0;
            data_oe_q <= 1'b0;
            ready_q   <= 1'b1;
            if (tx_if.tx_valid && ready_q) begin
              frame_q     <= {1'b1, ps2_odd_parity(tx_if.tx_data), tx_if.tx_data};
              inhib_cnt_q <= '0;
              clk_oe_q    <= 1'b1;
              ready_q     <= 1'b0;
              busy_q      <= 1'b1;
              error_q     <= 1'b0;
              state_q     <= StInhibit;
            end
          end
          StInhibit: begin
            if (inhib_cnt_q == InhibLast) begin
              data_oe_q <= 1'b1;
              state_q   <= StReq;
            end else begin
              inhib_cnt_q <= inhib_cnt_q + 1'b1;
            end
          end
          StReq: begin
            clk_oe_q <= 1'b0;
            wd_q     <= '0;
            state_q  <= StStart;
          end
          StStart: begin
            if (clk_fall) begin
              bit_idx_q <= '0;
              data_oe_q <= ~frame_q[0];
              state_q   <= StShift;
            end
          end
          StShift: begin
            if (clk_fall) begin
              if (bit_idx_q == 4'd9) begin
                ack_err_q <= data_level;
                data_oe_q <= 1'b0;
                state_q   <= StAck;
              end else begin
                bit_idx_q <= bit_idx_q + 1'b1;
                data_oe_q <= ~frame_q[bit_idx_q + 4'd1];
              end
            end
          end
          StAck: state_q <= StWaitIdle;
          StWaitIdle: begin
            if (clk_level && data_level) begin
              done_q  <= 1'b1;
              error_q <= ack_err_q;
              busy_q  <= 1'b0;
              state_q <= StIdle;
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  assign tx_if.tx_ready = ready_q;
  assign tx_if.busy     = busy_q;
  assign tx_if.done     = done_q;
  assign tx_if.error    = error_q;
  assign ps2_clk_oe_o   = clk_oe_q;
  assign ps2_data_oe_o  = data_oe_q;

endmodule
